// File: rtl/ibex_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_wb_pkg
// Description : Shared types and constants for the writeback/forwarding stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_wb_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_ALU       = 2'd1,
        WB_LOAD_WAIT = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/ibex_wb_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : ibex_wb_fwd_mux
// Description : Address compare and bypass mux for one register-file operand.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_wb_fwd_mux
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 i_wb_we,
    input  logic [RegAddrW-1:0]  i_wb_waddr,
    input  logic [DataWidth-1:0] i_wb_wdata,
    input  logic [RegAddrW-1:0]  i_raddr,
    input  logic [DataWidth-1:0] i_rf_rdata,
    output logic [DataWidth-1:0] o_fwd_rdata,
    output logic                 o_addr_match
);

    logic w_match;

    // RV32E only has 16 registers, so the top address bit is don't-care
    generate
        if (RV32E) begin : g_rv32e
            assign w_match = (i_raddr[3:0] == i_wb_waddr[3:0]);
        end else begin : g_rv32i
            assign w_match = (i_raddr == i_wb_waddr);
        end
    endgenerate

    assign o_addr_match = w_match;
    assign o_fwd_rdata  = (i_wb_we && w_match && (i_raddr != '0)) ? i_wb_wdata : i_rf_rdata;

endmodule
`default_nettype wire

// File: rtl/ibex_wb_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module      : ibex_wb_stage_fwd
// Description : Single-entry writeback stage with operand forwarding and
//               load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_wb_stage_fwd
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_wb_i,
    input  logic                 instr_is_load_i,
    input  logic                 rf_we_id_i,
    input  logic [RegAddrW-1:0]  rf_waddr_id_i,
    input  logic [DataWidth-1:0] rf_wdata_id_i,
    output logic                 ready_wb_o,
    input  logic                 lsu_resp_valid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    output logic [RegAddrW-1:0]  rf_waddr_wb_o,
    output logic [DataWidth-1:0] rf_wdata_wb_o,
    output logic                 rf_we_wb_o,
    input  logic [RegAddrW-1:0]  raddr_a_i,
    input  logic [RegAddrW-1:0]  raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] fwd_rdata_a_o,
    output logic [DataWidth-1:0] fwd_rdata_b_o,
    output logic                 ld_hazard_o,
    output logic                 instr_ret_o,
    output logic                 load_err_o
);

    wb_state_e             r_state;
    wb_state_e             w_state_next;
    logic                  r_we;
    logic [RegAddrW-1:0]   r_waddr;
    logic [DataWidth-1:0]  r_wdata;

    logic w_is_load;
    logic w_done;
    logic w_accept;
    logic w_match_a;
    logic w_match_b;

    assign w_is_load  = (r_state == WB_LOAD_WAIT);
    assign w_done     = (r_state == WB_ALU) || (w_is_load && lsu_resp_valid_i);
    assign ready_wb_o = (r_state == WB_IDLE) || w_done;
    assign w_accept   = en_wb_i && ready_wb_o;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = instr_is_load_i ? WB_LOAD_WAIT : WB_ALU;
        end else if (w_done) begin
            w_state_next = WB_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= WB_IDLE;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we    <= rf_we_id_i;
                r_waddr <= rf_waddr_id_i;
                r_wdata <= rf_wdata_id_i;
            end
        end
    end

    // An errored load retires but must never corrupt the register file
    assign rf_we_wb_o    = w_done && r_we && (r_waddr != '0) && !(w_is_load && lsu_err_i);
    assign rf_wdata_wb_o = w_is_load ? lsu_rdata_i : r_wdata;
    assign rf_waddr_wb_o = r_waddr;
    assign instr_ret_o   = w_done;
    assign load_err_o    = w_is_load && lsu_resp_valid_i && lsu_err_i;

    ibex_wb_fwd_mux #(
        .DataWidth (DataWidth),
        .RV32E     (RV32E)
    ) u_fwd_a (
        .i_wb_we      (rf_we_wb_o),
        .i_wb_waddr   (r_waddr),
        .i_wb_wdata   (rf_wdata_wb_o),
        .i_raddr      (raddr_a_i),
        .i_rf_rdata   (rf_rdata_a_i),
        .o_fwd_rdata  (fwd_rdata_a_o),
        .o_addr_match (w_match_a)
    );

    ibex_wb_fwd_mux #(
        .DataWidth (DataWidth),
        .RV32E     (RV32E)
    ) u_fwd_b (
        .i_wb_we      (rf_we_wb_o),
        .i_wb_waddr   (r_waddr),
        .i_wb_wdata   (rf_wdata_wb_o),
        .i_raddr      (raddr_b_i),
        .i_rf_rdata   (rf_rdata_b_i),
        .o_fwd_rdata  (fwd_rdata_b_o),
        .o_addr_match (w_match_b)
    );

    assign ld_hazard_o = w_is_load && !lsu_resp_valid_i && r_we && (r_waddr != '0)
                         && (w_match_a || w_match_b);

endmodule
`default_nettype wire

// File: tb/tb_ibex_wb_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_wb_stage_fwd
// Description : Self-checking bench for the writeback/forwarding stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_wb_stage_fwd;

    localparam logic [31:0] RDA = 32'hAAAA_0001;
    localparam logic [31:0] RDB = 32'hBBBB_0002;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_wb_i, instr_is_load_i, rf_we_id_i;
    logic [4:0]  rf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic        lsu_resp_valid_i, lsu_err_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic [31:0] rf_rdata_a_i, rf_rdata_b_i;

    logic        ready_wb_o, rf_we_wb_o, ld_hazard_o, instr_ret_o, load_err_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o, fwd_rdata_a_o, fwd_rdata_b_o;

    logic        e_ready, e_we, e_hz, e_ret, e_lerr;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_fwd_a, e_fwd_b;

    always #5 clk_i = ~clk_i;

    ibex_wb_stage_fwd #(.DataWidth(32), .RV32E(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
        .instr_is_load_i(instr_is_load_i), .rf_we_id_i(rf_we_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i),
        .ready_wb_o(ready_wb_o), .lsu_resp_valid_i(lsu_resp_valid_i),
        .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o),
        .rf_we_wb_o(rf_we_wb_o), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .fwd_rdata_a_o(fwd_rdata_a_o), .fwd_rdata_b_o(fwd_rdata_b_o),
        .ld_hazard_o(ld_hazard_o), .instr_ret_o(instr_ret_o), .load_err_o(load_err_o)
    );

    ibex_wb_stage_fwd #(.DataWidth(32), .RV32E(1'b1)) dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i),
        .instr_is_load_i(instr_is_load_i), .rf_we_id_i(rf_we_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i),
        .ready_wb_o(e_ready), .lsu_resp_valid_i(lsu_resp_valid_i),
        .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .rf_waddr_wb_o(e_waddr), .rf_wdata_wb_o(e_wdata),
        .rf_we_wb_o(e_we), .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .fwd_rdata_a_o(e_fwd_a), .fwd_rdata_b_o(e_fwd_b),
        .ld_hazard_o(e_hz), .instr_ret_o(e_ret), .load_err_o(e_lerr)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard of expected RF writes, pushed when the instruction is driven
    typedef struct { logic [4:0] waddr; logic [31:0] wdata; } wr_t;
    wr_t sb_q[$];
    bit  sb_on = 1'b0;
    int  sb_writes = 0;

    always @(negedge clk_i) begin
        if (sb_on && rf_we_wb_o) begin
            sb_writes++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write_addr", {27'd0, rf_waddr_wb_o}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_waddr", {27'd0, rf_waddr_wb_o}, {27'd0, e.waddr});
                chk("sb_wdata", rf_wdata_wb_o, e.wdata);
            end
        end
    end

    typedef struct {
        logic en, ld, we; logic [4:0] wa; logic [31:0] wd;
        logic rv; logic [31:0] rd; logic er; logic [4:0] ra, rb;
        logic x_ready, x_we; logic [4:0] x_wa; logic [31:0] x_wd, x_fa, x_fb;
        logic x_hz, x_ret, x_err;
    } vec_t;

    function automatic vec_t mk(
        logic en, logic ld, logic we, logic [4:0] wa, logic [31:0] wd,
        logic rv, logic [31:0] rd, logic er, logic [4:0] ra, logic [4:0] rb,
        logic x_ready, logic x_we, logic [4:0] x_wa, logic [31:0] x_wd,
        logic [31:0] x_fa, logic [31:0] x_fb, logic x_hz, logic x_ret, logic x_err);
        vec_t v;
        v.en = en; v.ld = ld; v.we = we; v.wa = wa; v.wd = wd;
        v.rv = rv; v.rd = rd; v.er = er; v.ra = ra; v.rb = rb;
        v.x_ready = x_ready; v.x_we = x_we; v.x_wa = x_wa; v.x_wd = x_wd;
        v.x_fa = x_fa; v.x_fb = x_fb; v.x_hz = x_hz; v.x_ret = x_ret; v.x_err = x_err;
        return v;
    endfunction

    task automatic clr();
        en_wb_i = 0; instr_is_load_i = 0; rf_we_id_i = 0; rf_waddr_id_i = 0;
        rf_wdata_id_i = 0; lsu_resp_valid_i = 0; lsu_rdata_i = 0; lsu_err_i = 0;
        raddr_a_i = 0; raddr_b_i = 0;
    endtask

    task automatic drive_instr(input logic ld, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
        en_wb_i = 1; instr_is_load_i = ld; rf_we_id_i = we;
        rf_waddr_id_i = wa; rf_wdata_id_i = wd;
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rf_rdata_a_i = RDA;
        rf_rdata_b_i = RDB;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        //           en ld we wa  wd            rv rd            er ra  rb   rdy we wa  wd            fa            fb            hz ret err
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 5,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(1, 0, 1, 5,  32'h1234,     0, 32'h0,        0, 5,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 5,  0,   1, 1, 5,  32'h1234,     32'h1234,     RDB,          0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 5,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0,  32'h55,       0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(1, 0, 1, 6,  32'h66,       0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 1, 0));
        vq.push_back(mk(1, 1, 1, 7,  32'h0,        0, 32'h0,        0, 6,  0,   1, 1, 6,  32'h66,       32'h66,       RDB,          0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 7,  0,   0, 0, 0,  32'h0,        RDA,          RDB,          1, 0, 0));
        vq.push_back(mk(1, 0, 1, 8,  32'h88,       0, 32'h0,        0, 7,  0,   0, 0, 0,  32'h0,        RDA,          RDB,          1, 0, 0));
        vq.push_back(mk(1, 0, 1, 8,  32'h88,       1, 32'hDEADBEEF, 0, 7,  0,   1, 1, 7,  32'hDEADBEEF, 32'hDEADBEEF, RDB,          0, 1, 0));
        vq.push_back(mk(1, 1, 1, 9,  32'h0,        1, 32'hBAD,      1, 0,  8,   1, 1, 8,  32'h88,       RDA,          32'h88,       0, 1, 0));
        vq.push_back(mk(1, 0, 1, 10, 32'hA0,       1, 32'h99,       1, 9,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 10, 10,  1, 1, 10, 32'hA0,       32'hA0,       32'hA0,       0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(1, 1, 0, 11, 32'h0,        0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 11, 0,   0, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        1, 32'h77,       0, 11, 0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 1, 0));
        vq.push_back(mk(1, 1, 1, 12, 32'h0,        0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 0,  12,  0, 0, 0,  32'h0,        RDA,          RDB,          1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        1, 32'hC,        0, 0,  12,  1, 1, 12, 32'hC,        RDA,          32'hC,        0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0,  32'h0,        0, 32'h0,        0, 0,  0,   1, 0, 0,  32'h0,        RDA,          RDB,          0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            en_wb_i = v.en; instr_is_load_i = v.ld; rf_we_id_i = v.we;
            rf_waddr_id_i = v.wa; rf_wdata_id_i = v.wd;
            lsu_resp_valid_i = v.rv; lsu_rdata_i = v.rd; lsu_err_i = v.er;
            raddr_a_i = v.ra; raddr_b_i = v.rb;
            @(negedge clk_i);
            chk($sformatf("v%0d_ready", i), {31'd0, ready_wb_o}, {31'd0, v.x_ready});
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we_wb_o}, {31'd0, v.x_we});
            if (v.x_we) begin
                chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr_wb_o}, {27'd0, v.x_wa});
                chk($sformatf("v%0d_wdata", i), rf_wdata_wb_o, v.x_wd);
            end
            chk($sformatf("v%0d_fwd_a", i), fwd_rdata_a_o, v.x_fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_rdata_b_o, v.x_fb);
            chk($sformatf("v%0d_hazard", i), {31'd0, ld_hazard_o}, {31'd0, v.x_hz});
            chk($sformatf("v%0d_ret", i), {31'd0, instr_ret_o}, {31'd0, v.x_ret});
            chk($sformatf("v%0d_load_err", i), {31'd0, load_err_o}, {31'd0, v.x_err});
            next();
        end
        clr();

        // Back-to-back ALU stream: no bubbles, writes in order
        sb_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_t w;
            w.waddr = 5'(i + 1);
            w.wdata = $urandom;
            drive_instr(1'b0, 1'b1, w.waddr, w.wdata);
            sb_q.push_back(w);
            @(negedge clk_i);
            chk($sformatf("b2b%0d_ready", i), {31'd0, ready_wb_o}, 32'd1);
            next();
        end
        clr();
        next();
        next();
        chk("b2b_writes", sb_writes, 32'd8);
        chk("b2b_queue_empty", sb_q.size(), 32'd0);

        // Load to x7, response three cycles later
        begin
            wr_t w;
            w.waddr = 5'd7;
            w.wdata = 32'hDEADBEEF;
            drive_instr(1'b1, 1'b1, 5'd7, 32'h0);
            sb_q.push_back(w);
            next();
            clr();
            raddr_a_i = 5'd7;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk_i);
                chk($sformatf("ld_wait%0d_ready", c), {31'd0, ready_wb_o}, 32'd0);
                chk($sformatf("ld_wait%0d_hazard", c), {31'd0, ld_hazard_o}, 32'd1);
                next();
            end
            lsu_resp_valid_i = 1'b1;
            lsu_rdata_i = 32'hDEADBEEF;
            @(negedge clk_i);
            chk("ld_resp_ready", {31'd0, ready_wb_o}, 32'd1);
            chk("ld_resp_hazard", {31'd0, ld_hazard_o}, 32'd0);
            chk("ld_resp_fwd_a", fwd_rdata_a_o, 32'hDEADBEEF);
            next();
            clr();
            next();
            chk("ld_queue_empty", sb_q.size(), 32'd0);
        end

        // Asynchronous reset while a load is pending drops it
        drive_instr(1'b1, 1'b1, 5'd13, 32'h0);
        next();
        clr();
        raddr_a_i = 5'd13;
        @(negedge clk_i);
        chk("rst_pre_hazard", {31'd0, ld_hazard_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready_wb_o}, 32'd1);
        chk("rst_hazard", {31'd0, ld_hazard_o}, 32'd0);
        chk("rst_waddr", {27'd0, rf_waddr_wb_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next();
        lsu_resp_valid_i = 1'b1;
        lsu_rdata_i = 32'h1313;
        @(negedge clk_i);
        chk("late_resp_we", {31'd0, rf_we_wb_o}, 32'd0);
        chk("late_resp_ret", {31'd0, instr_ret_o}, 32'd0);
        chk("late_resp_err", {31'd0, load_err_o}, 32'd0);
        next();
        clr();

        // RV32E aliasing: x19 reads the x3 being written back
        begin
            wr_t w;
            w.waddr = 5'd3;
            w.wdata = 32'h3333;
            drive_instr(1'b0, 1'b1, 5'd3, 32'h3333);
            sb_q.push_back(w);
            next();
            clr();
            raddr_a_i = 5'd19;
            raddr_b_i = 5'd3;
            @(negedge clk_i);
            chk("e_fwd_a", e_fwd_a, 32'h3333);
            chk("e_fwd_b", e_fwd_b, 32'h3333);
            chk("e_we", {31'd0, e_we}, 32'd1);
            chk("i_fwd_a_no_alias", fwd_rdata_a_o, RDA);
            chk("i_fwd_b", fwd_rdata_b_o, 32'h3333);
            next();
            next();
            chk("e_queue_empty", sb_q.size(), 32'd0);
        end
        sb_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
